// File: rtl/pc_byte_sequencer.sv
// Byte-serial program counter load (MSB first) and save (LSB first), plus a cache register.
// Latency: an operation takes PC_BYTES accepted bytes; load_done pulses the cycle after the final byte.
// Backpressure: mem_ready low stalls the byte counter; start requests while busy are dropped.
module pc_byte_sequencer #(
   parameter int PC_BYTES   = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [DATA_WIDTH-1:0]            alu_out,
   input  logic                             cache_write,
   input  logic [PC_BYTES*DATA_WIDTH-1:0]   pc,
   input  logic [DATA_WIDTH-1:0]            mem_out,
   input  logic                             mem_ready,
   input  logic                             load_start,
   input  logic                             save_start,
   output logic [PC_BYTES*DATA_WIDTH-1:0]   load_out,
   output logic                             load_done,
   output logic [DATA_WIDTH-1:0]            save_out,
   output logic                             save_valid,
   output logic                             save_last,
   output logic [$clog2(PC_BYTES)-1:0]      byte_index,
   output logic                             busy,
   output logic [DATA_WIDTH-1:0]            cache_out
);

   localparam int PW = PC_BYTES * DATA_WIDTH;
   localparam int CW = $clog2(PC_BYTES);
   localparam logic [CW-1:0] LAST = CW'(PC_BYTES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SAVE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         cnt;
   logic [PW-1:0]         shadow;
   logic [PW-1:0]         shadow_nxt;
   logic [PW-1:0]         snap;
   logic [PW-1:0]         load_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] cache_q;
   logic                  xfer;
   logic                  last_xfer;

   // A byte moves whenever a transfer is active and memory completes it.
   assign xfer      = (state != IDLE) && mem_ready;
   assign last_xfer = xfer && (cnt == LAST);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: load has priority over save; requests while busy are ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load_start)      state_nxt = LOAD;
            else if (save_start) state_nxt = SAVE;
         end
         LOAD, SAVE: begin
            if (last_xfer) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: save stream is driven only in SAVE, everything is zero in IDLE.
   always_comb begin
      busy       = (state != IDLE);
      save_valid = 1'b0;
      save_last  = 1'b0;
      save_out   = '0;
      if (state == SAVE) begin
         save_valid = 1'b1;
         save_last  = (cnt == LAST);
         for (int i = 0; i < PC_BYTES; i++) begin
            if (i == int'(cnt)) save_out = snap[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Merge the incoming byte into the shadow, most significant byte at counter 0.
   always_comb begin
      shadow_nxt = shadow;
      for (int i = 0; i < PC_BYTES; i++) begin
         if (i == PC_BYTES - 1 - int'(cnt)) shadow_nxt[i*DATA_WIDTH +: DATA_WIDTH] = mem_out;
      end
   end

   // Byte counter: cleared in IDLE and after the final byte, so it never wraps mid-transfer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)              cnt <= '0;
      else if (state == IDLE) cnt <= '0;
      else if (xfer)          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   // Load datapath: load_out only changes with a complete value, done pulses one cycle later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow <= '0;
         load_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == LOAD && xfer) begin
            shadow <= shadow_nxt;
            if (cnt == LAST) begin
               load_q <= shadow_nxt;
               done_q <= 1'b1;
            end
         end
      end
   end

   // Snapshot pc on entry to SAVE so later pc changes cannot corrupt the stream.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                              snap <= '0;
      else if (state == IDLE && save_start && !load_start)    snap <= pc;
   end

   // Cache register, written independently of the sequencer state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)            cache_q <= '0;
      else if (cache_write) cache_q <= alu_out;
   end

   assign load_out   = load_q;
   assign load_done  = done_q;
   assign byte_index = cnt;
   assign cache_out  = cache_q;

endmodule

// File: tb/tb_pc_byte_sequencer.sv
module tb_pc_byte_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  alu_out = '0;
   logic        cache_write = 1'b0;
   logic [7:0]  mem_out = '0;
   logic        mem_ready = 1'b0;

   logic [15:0] pc2 = '0;
   logic        ls2 = 1'b0, ss2 = 1'b0;
   logic [15:0] d2_load_out;
   logic        d2_load_done, d2_save_valid, d2_save_last, d2_busy;
   logic [7:0]  d2_save_out, d2_cache_out;
   logic [0:0]  d2_byte_index;

   logic [23:0] pc3 = '0;
   logic        ls3 = 1'b0, ss3 = 1'b0;
   logic [23:0] d3_load_out;
   logic        d3_load_done, d3_save_valid, d3_save_last, d3_busy;
   logic [7:0]  d3_save_out, d3_cache_out;
   logic [1:0]  d3_byte_index;

   int n_vec = 0;
   int n_err = 0;

   logic [23:0] q_l2[$];
   logic [23:0] q_l3[$];
   logic [8:0]  q_s2[$];
   logic [8:0]  q_s3[$];

   pc_byte_sequencer #(.PC_BYTES(2), .DATA_WIDTH(8)) d2 (
      .clock(clock), .reset(reset), .alu_out(alu_out), .cache_write(cache_write),
      .pc(pc2), .mem_out(mem_out), .mem_ready(mem_ready),
      .load_start(ls2), .save_start(ss2),
      .load_out(d2_load_out), .load_done(d2_load_done), .save_out(d2_save_out),
      .save_valid(d2_save_valid), .save_last(d2_save_last), .byte_index(d2_byte_index),
      .busy(d2_busy), .cache_out(d2_cache_out));

   pc_byte_sequencer #(.PC_BYTES(3), .DATA_WIDTH(8)) d3 (
      .clock(clock), .reset(reset), .alu_out(alu_out), .cache_write(cache_write),
      .pc(pc3), .mem_out(mem_out), .mem_ready(mem_ready),
      .load_start(ls3), .save_start(ss3),
      .load_out(d3_load_out), .load_done(d3_load_done), .save_out(d3_save_out),
      .save_valid(d3_save_valid), .save_last(d3_save_last), .byte_index(d3_byte_index),
      .busy(d3_busy), .cache_out(d3_cache_out));

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: output seen with no expected entry", name);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Monitor for the 2-byte instance.
   always @(negedge clock) begin
      if (d2_load_done) begin
         if (q_l2.size() == 0) unexpected("d2 load_done");
         else check("d2 load_out", {16'h0, d2_load_out}, {8'h0, q_l2.pop_front()});
      end
      if (d2_save_valid && mem_ready) begin
         if (q_s2.size() == 0) unexpected("d2 save byte");
         else check("d2 save byte", {23'h0, d2_save_last, d2_save_out}, {23'h0, q_s2.pop_front()});
      end
   end

   // Monitor for the 3-byte instance.
   always @(negedge clock) begin
      if (d3_load_done) begin
         if (q_l3.size() == 0) unexpected("d3 load_done");
         else check("d3 load_out", {8'h0, d3_load_out}, {8'h0, q_l3.pop_front()});
      end
      if (d3_save_valid && mem_ready) begin
         if (q_s3.size() == 0) unexpected("d3 save byte");
         else check("d3 save byte", {23'h0, d3_save_last, d3_save_out}, {23'h0, q_s3.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick; tick;
      check("rst load_out", d2_load_out, 0);
      check("rst busy", d2_busy, 0);
      check("rst save_valid", d2_save_valid, 0);
      check("rst load_done", d2_load_done, 0);
      check("rst cache_out", d2_cache_out, 0);
      check("rst byte_index", d2_byte_index, 0);
      reset = 1'b0;
      tick;

      // Basic load 0x12, 0x34
      ls2 = 1'b1; q_l2.push_back(24'h1234);
      tick;
      ls2 = 1'b0; mem_ready = 1'b1; mem_out = 8'h12;
      check("load busy c1", d2_busy, 1);
      tick;
      mem_out = 8'h34;
      check("load busy c2", d2_busy, 1);
      check("load partial hidden", d2_load_out, 0);
      tick;
      mem_ready = 1'b0;
      check("load busy end", d2_busy, 0);
      check("load_done high", d2_load_done, 1);
      tick;
      check("load_done pulse width", d2_load_done, 0);

      // Save 0xBEEF with pc changed mid-save and one stall
      pc2 = 16'hBEEF; ss2 = 1'b1;
      q_s2.push_back({1'b0, 8'hEF}); q_s2.push_back({1'b1, 8'hBE});
      tick;
      ss2 = 1'b0; pc2 = 16'h0000;
      check("save first byte", d2_save_out, 8'hEF);
      check("save first last", d2_save_last, 0);
      tick;
      check("save stall hold", d2_save_out, 8'hEF);
      check("save stall index", d2_byte_index, 0);
      mem_ready = 1'b1;
      tick;
      check("save index 1", d2_byte_index, 1);
      tick;
      mem_ready = 1'b0;
      check("save idle valid", d2_save_valid, 0);
      check("save idle out", d2_save_out, 0);
      check("save idle busy", d2_busy, 0);

      // Load with a 3-cycle stall between bytes
      ls2 = 1'b1; q_l2.push_back(24'hA53C);
      tick;
      ls2 = 1'b0; mem_ready = 1'b1; mem_out = 8'hA5;
      tick;
      mem_ready = 1'b0; mem_out = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("stall load_out old", d2_load_out, 16'h1234);
         check("stall index", d2_byte_index, 1);
      end
      mem_ready = 1'b1; mem_out = 8'h3C;
      tick;
      mem_ready = 1'b0;
      tick;

      // Simultaneous start: load wins, save during load ignored
      ls2 = 1'b1; ss2 = 1'b1; pc2 = 16'h1111; q_l2.push_back(24'h0102);
      tick;
      ls2 = 1'b0;
      check("both start save_valid", d2_save_valid, 0);
      check("both start busy", d2_busy, 1);
      mem_ready = 1'b1; mem_out = 8'h01;
      tick;
      check("save ignored in load", d2_save_valid, 0);
      mem_out = 8'h02;
      tick;
      ss2 = 1'b0; mem_ready = 1'b0;
      tick;
      check("no save after load", d2_save_valid, 0);
      check("no busy after load", d2_busy, 0);

      // Reset in the middle of a load
      ls2 = 1'b1;
      tick;
      ls2 = 1'b0; mem_ready = 1'b1; mem_out = 8'h77;
      tick;
      mem_ready = 1'b0; reset = 1'b1;
      #1;
      check("abort load_out", d2_load_out, 0);
      check("abort busy", d2_busy, 0);
      check("abort load_done", d2_load_done, 0);
      tick;
      // First request after release is taken on the first edge
      reset = 1'b0; ss2 = 1'b1; pc2 = 16'hC3A5;
      q_s2.push_back({1'b0, 8'hA5}); q_s2.push_back({1'b1, 8'hC3});
      tick;
      ss2 = 1'b0;
      check("first edge accepted", d2_busy, 1);
      cache_write = 1'b1; alu_out = 8'h5A; mem_ready = 1'b1;
      tick;
      cache_write = 1'b0; alu_out = 8'h33;
      check("cache write in save", d2_cache_out, 8'h5A);
      tick;
      mem_ready = 1'b0;
      tick;
      check("cache hold", d2_cache_out, 8'h5A);
      check("abort no load_out", d2_load_out, 0);

      // 3-byte instance: load then save
      ls3 = 1'b1; q_l3.push_back(24'hAABBCC);
      tick;
      ls3 = 1'b0; mem_ready = 1'b1; mem_out = 8'hAA;
      tick;
      mem_out = 8'hBB;
      tick;
      check("d3 index 2", d3_byte_index, 2);
      mem_out = 8'hCC;
      tick;
      mem_ready = 1'b0;
      check("d3 load idle", d3_busy, 0);
      tick;
      pc3 = 24'h010203; ss3 = 1'b1;
      q_s3.push_back({1'b0, 8'h03}); q_s3.push_back({1'b0, 8'h02}); q_s3.push_back({1'b1, 8'h01});
      tick;
      ss3 = 1'b0; mem_ready = 1'b1;
      tick; tick;
      check("d3 save busy", d3_busy, 1);
      tick;
      mem_ready = 1'b0;
      check("d3 save idle", d3_busy, 0);
      tick; tick;

      check("d2 load queue drained", q_l2.size(), 0);
      check("d2 save queue drained", q_s2.size(), 0);
      check("d3 load queue drained", q_l3.size(), 0);
      check("d3 save queue drained", q_s3.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
